// File: rtl/uart_instruction_assembler.sv
// uart_instruction_assembler: frames HEADER_BYTE + PAYLOAD_BYTES + XOR checksum into a 147-bit instruction
//   clk, rst          : clock, synchronous active-high reset
//   rx_data, rx_valid : byte stream from the UART receiver
//   fifo_full         : downstream FIFO cannot accept a write
//   instruction_valid : one-cycle write strobe, instruction valid with it
//   instruction       : assembled instruction, held until the next strobe
//   busy              : frame in progress or instruction pending
//   chk_err, timeout_err, overflow : sticky error flags, cleared by rst only
module uart_instruction_assembler #(
    parameter logic [7:0] HEADER_BYTE   = 8'hA5,
    parameter int         PAYLOAD_BYTES = 19,
    parameter int         TIMEOUT_CYC   = 100000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    input  logic         fifo_full,
    output logic         instruction_valid,
    output logic [146:0] instruction,
    output logic         busy,
    output logic         chk_err,
    output logic         timeout_err,
    output logic         overflow
);
    localparam int CW = $clog2(PAYLOAD_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, PAYLOAD, CHECK, EMIT, HOLD} state_t;

    state_t         state_q, state_d;
    logic [146:0]   sr_q, sr_d, instr_q, instr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     xor_q, xor_d;
    logic [TW-1:0]  to_q, to_d;
    logic           chk_err_q, chk_err_d, timeout_err_q, timeout_err_d, overflow_q, overflow_d;
    logic           start, shift, in_frame, timeout_hit, chk_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            sr_q          <= '0;
            instr_q       <= '0;
            cnt_q         <= '0;
            xor_q         <= '0;
            to_q          <= '0;
            chk_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            instr_q       <= instr_d;
            cnt_q         <= cnt_d;
            xor_q         <= xor_d;
            to_q          <= to_d;
            chk_err_q     <= chk_err_d;
            timeout_err_q <= timeout_err_d;
            overflow_q    <= overflow_d;
        end
    end

    always_comb begin
        start       = state_q == IDLE && rx_valid && rx_data == HEADER_BYTE;
        shift       = state_q == PAYLOAD && rx_valid;
        in_frame    = state_q == PAYLOAD || state_q == CHECK;
        timeout_hit = in_frame && !rx_valid && to_q == TW'(TIMEOUT_CYC - 1);
        chk_ok      = rx_data == xor_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = start ? PAYLOAD : IDLE;
            PAYLOAD: state_d = shift ? (cnt_q == CW'(PAYLOAD_BYTES - 1) ? CHECK : PAYLOAD)
                                     : (timeout_hit ? IDLE : PAYLOAD);
            CHECK:   state_d = rx_valid ? (chk_ok ? (fifo_full ? HOLD : EMIT) : IDLE)
                                        : (timeout_hit ? IDLE : CHECK);
            EMIT:    state_d = IDLE;
            HOLD:    state_d = fifo_full ? HOLD : EMIT;
            default: state_d = IDLE;
        endcase
    end

    // The shift register keeps only the low 147 bits; the top 5 bits of P0 fall off the end.
    // The instruction register loads on entry to EMIT so the data is present with the strobe.
    always_comb begin
        sr_d          = shift ? {sr_q[138:0], rx_data} : sr_q;
        cnt_d         = start ? '0 : shift ? cnt_q + 1'b1 : cnt_q;
        xor_d         = start ? '0 : shift ? xor_q ^ rx_data : xor_q;
        to_d          = in_frame && !rx_valid ? to_q + 1'b1 : '0;
        instr_d       = state_d == EMIT ? sr_q : instr_q;
        chk_err_d     = chk_err_q | (state_q == CHECK && rx_valid && !chk_ok);
        timeout_err_d = timeout_err_q | timeout_hit;
        overflow_d    = overflow_q | (state_q == HOLD && rx_valid);
    end

    always_comb begin
        instruction_valid = state_q == EMIT;
        busy              = state_q != IDLE;
        instruction       = instr_q;
        chk_err           = chk_err_q;
        timeout_err       = timeout_err_q;
        overflow          = overflow_q;
    end
endmodule

// File: tb/tb_uart_instruction_assembler.sv
// tb_uart_instruction_assembler: scoreboard bench for uart_instruction_assembler
module tb_uart_instruction_assembler;
    localparam int TO = 200;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         fifo_full;
    logic         instruction_valid;
    logic [146:0] instruction;
    logic         busy, chk_err, timeout_err, overflow;

    int           vectors = 0;
    int           miscompares = 0;
    int           pulses = 0;
    logic [146:0] sb [$];
    logic [7:0]   pl [19];

    uart_instruction_assembler #(.HEADER_BYTE(8'hA5), .PAYLOAD_BYTES(19), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .fifo_full(fifo_full),
        .instruction_valid(instruction_valid), .instruction(instruction), .busy(busy),
        .chk_err(chk_err), .timeout_err(timeout_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // Every strobe must match the oldest expected instruction and never coincide with fifo_full.
    always @(negedge clk) begin
        if (instruction_valid) begin
            logic [146:0] e;
            pulses++;
            vectors += 2;
            if (fifo_full !== 1'b0) begin
                miscompares++;
                $display("FAIL pulse_while_full: fifo_full=%b, required 0", fifo_full);
            end
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: instruction=%h, required no pulse", instruction);
            end else begin
                e = sb.pop_front();
                if (instruction !== e) begin
                    miscompares++;
                    $display("FAIL instruction: got %h, required %h", instruction, e);
                end
            end
        end
    end

    function automatic logic [146:0] exp_of();
        logic [151:0] v;
        for (int i = 0; i < 19; i++) v[8*(18-i) +: 8] = pl[i];
        return v[146:0];
    endfunction

    function automatic logic [7:0] chk_of();
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 19; i++) x ^= pl[i];
        return x;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_body(input int n);
        send_byte(8'hA5);
        for (int i = 0; i < n; i++) send_byte(pl[i]);
    endtask

    task automatic expect_bit(input string name, input logic got, input logic req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic good_frame(input string name);
        int p0;
        sb.push_back(exp_of());
        send_body(19);
        p0 = pulses;
        send_byte(chk_of());
        expect_bit({name, "_pulse"}, instruction_valid, 1'b1);
        tick(1);
        expect_bit({name, "_single"}, instruction_valid, 1'b0);
        expect_bit({name, "_idle"}, busy, 1'b0);
        vectors++;
        if (pulses - p0 !== 1) begin
            miscompares++;
            $display("FAIL %s_count: got %0d pulses, required 1", name, pulses - p0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        expect_bit("rst_valid", instruction_valid, 1'b0);
        expect_bit("rst_busy", busy, 1'b0);
        expect_bit("rst_chk_err", chk_err, 1'b0);
        expect_bit("rst_timeout_err", timeout_err, 1'b0);
        expect_bit("rst_overflow", overflow, 1'b0);
        vectors++;
        if (instruction !== 147'd0) begin
            miscompares++;
            $display("FAIL rst_instruction: got %h, required 0", instruction);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_basic();
        for (int i = 0; i < 19; i++) pl[i] = 8'(i);
        good_frame("basic");
    endtask

    task automatic test_bad_chk();
        for (int i = 0; i < 19; i++) pl[i] = 8'(i);
        send_body(19);
        send_byte(chk_of() ^ 8'h01);
        expect_bit("badchk_no_pulse", instruction_valid, 1'b0);
        expect_bit("badchk_flag", chk_err, 1'b1);
        expect_bit("badchk_idle", busy, 1'b0);
        tick(3);
        for (int i = 0; i < 19; i++) pl[i] = 8'($urandom);
        good_frame("after_badchk");
    endtask

    task automatic test_hold();
        int bad = 0;
        for (int i = 0; i < 19; i++) pl[i] = 8'($urandom);
        sb.push_back(exp_of());
        send_body(19);
        fifo_full = 1'b1;
        send_byte(chk_of());
        for (int i = 0; i < 50; i++) begin
            if (instruction_valid !== 1'b0) bad++;
            tick(1);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL hold_no_pulse: got %0d pulsing cycles, required 0", bad);
        end
        expect_bit("hold_busy", busy, 1'b1);
        fifo_full = 1'b0;
        tick(1);
        expect_bit("hold_release_pulse", instruction_valid, 1'b1);
        tick(1);
        expect_bit("hold_release_once", instruction_valid, 1'b0);
        expect_bit("hold_release_idle", busy, 1'b0);
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 19; i++) pl[i] = 8'($urandom);
        send_body(19);
        tick(TO - 10);
        expect_bit("timeout_not_yet", timeout_err, 1'b0);
        expect_bit("timeout_still_busy", busy, 1'b1);
        tick(15);
        expect_bit("timeout_flag", timeout_err, 1'b1);
        expect_bit("timeout_idle", busy, 1'b0);
        for (int i = 0; i < 19; i++) pl[i] = 8'($urandom);
        good_frame("after_timeout");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 19; i++) pl[i] = 8'($urandom);
        send_body(10);
        expect_bit("mid_busy", busy, 1'b1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        expect_bit("mid_rst_busy", busy, 1'b0);
        expect_bit("mid_rst_chk_err", chk_err, 1'b0);
        expect_bit("mid_rst_timeout_err", timeout_err, 1'b0);
        vectors++;
        if (instruction !== 147'd0) begin
            miscompares++;
            $display("FAIL mid_rst_instruction: got %h, required 0", instruction);
        end
        for (int i = 0; i < 19; i++) pl[i] = 8'($urandom);
        good_frame("after_mid_rst");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 19; i++) pl[i] = 8'($urandom);
        sb.push_back(exp_of());
        send_body(19);
        fifo_full = 1'b1;
        send_byte(chk_of());
        tick(3);
        send_byte(8'hA5);
        tick(2);
        expect_bit("ovf_flag", overflow, 1'b1);
        expect_bit("ovf_busy", busy, 1'b1);
        fifo_full = 1'b0;
        tick(1);
        expect_bit("ovf_release_pulse", instruction_valid, 1'b1);
        tick(1);
        expect_bit("ovf_no_new_frame", busy, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 19; i++) pl[i] = 8'($urandom);
        pl[0] = 8'hA5;
        pl[7] = 8'hA5;
        good_frame("b2b_first");
        for (int i = 0; i < 19; i++) pl[i] = 8'hFF - 8'(i);
        pl[18] = 8'hA5;
        good_frame("b2b_second");
    endtask

    initial begin
        rst       = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        fifo_full = 1'b0;
        test_reset();
        test_basic();
        test_bad_chk();
        test_hold();
        test_timeout();
        test_reset_mid();
        test_overflow();
        test_back_to_back();
        tick(5);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
